// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encoding and full-subtractor cell equation
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bi);
        logic d;
        logic bo;
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
        return {bo, d};
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign {bo, d} = sub_cell(a, b, bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, with start/busy/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // The final bit goes straight into diff, so only WIDTH-1 partial bits are kept.
    logic [WIDTH-2:0] diff_sr;
    logic             brw;
    logic [CW-1:0]    count;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last_bit;

    full_subtractor u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (state == ST_SHIFT) && (count == LAST);
    assign busy     = (state == ST_SHIFT);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (count == LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            count   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            count <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= {cell_d, diff_sr[WIDTH-2:1]};
            brw     <= cell_bo;
            count   <= count + CW'(1);
            // On the last bit a_sr[0]/b_sr[0] hold the original operand MSBs.
            if (last_bit) begin
                diff <= {cell_d, diff_sr};
                bout <= cell_bo;
                ovf  <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
            end
        end
    end

endmodule
